// File: rtl/nb_update_engine.sv
// nb_update_engine: loads a/b/c/d, then iterates N steps of
// a <= b&c; d <= a^d; c <= a|b with either parallel (non-blocking)
// or serial (blocking) evaluation. valid/ready handshake on load and result.
//
// state | meaning
// IDLE  | waiting for a load; load_ready high
// RUN   | one update step per clock; busy high
// DONE  | result held on res_*; res_valid high until res_ready
module nb_update_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  input  logic [WIDTH-1:0] load_c,
  input  logic [WIDTH-1:0] load_d,
  input  logic [CNT_W-1:0] num_steps,
  input  logic             blk_mode,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_c,
  output logic [WIDTH-1:0] res_d
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, c, d;
  logic [WIDTH-1:0] a_nxt, c_nxt, d_nxt;
  logic [CNT_W-1:0] n_reg;
  logic             mode_reg;
  logic             accept;
  logic             step_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; flush overrides load accept and res_ready
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            accept    = 1'b1;
            state_nxt = (num_steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          step_en = 1'b1;
          // n_reg is nonzero whenever RUN is entered, so n_reg-1 cannot underflow
          if (step_cnt == n_reg - CNT_W'(1)) state_nxt = DONE;
        end
        DONE: begin
          if (res_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // One update step; in serial mode d and c see the freshly computed a
  always_comb begin
    a_nxt = b & c;
    d_nxt = mode_reg ? (a_nxt ^ d) : (a ^ d);
    c_nxt = mode_reg ? (a_nxt | b) : (a | b);
  end

  // Operand, configuration and step-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      d        <= '0;
      n_reg    <= '0;
      mode_reg <= 1'b0;
      step_cnt <= '0;
    end else if (accept) begin
      a        <= load_a;
      b        <= load_b;
      c        <= load_c;
      d        <= load_d;
      n_reg    <= num_steps;
      mode_reg <= blk_mode;
      step_cnt <= '0;
    end else if (step_en) begin
      a        <= a_nxt;
      c        <= c_nxt;
      d        <= d_nxt;
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);
  assign res_valid  = (state == DONE);
  assign res_a      = a;
  assign res_c      = c;
  assign res_d      = d;

endmodule

// File: tb/tb_nb_update_engine.sv
// Directed bench for nb_update_engine with hand-computed expectations.
module tb_nb_update_engine;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_a, load_b, load_c, load_d;
  logic [CNT_W-1:0] num_steps;
  logic             blk_mode;
  logic             busy;
  logic [CNT_W-1:0] step_cnt;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_a, res_c, res_d;

  int checks = 0;
  int errors = 0;

  nb_update_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_a(load_a), .load_b(load_b), .load_c(load_c), .load_d(load_d),
    .num_steps(num_steps), .blk_mode(blk_mode),
    .busy(busy), .step_cnt(step_cnt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_c(res_c), .res_d(res_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [7:0] n, input logic m);
    load_a = a; load_b = b; load_c = c; load_d = d;
    num_steps = n; blk_mode = m; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] ea,
                           input logic [31:0] ec, input logic [31:0] ed);
    chk({tag, "_a"}, 64'(res_a), 64'(ea));
    chk({tag, "_c"}, 64'(res_c), 64'(ec));
    chk({tag, "_d"}, 64'(res_d), 64'(ed));
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; load_valid = 1'b0; res_ready = 1'b0;
    load_a = '0; load_b = '0; load_c = '0; load_d = '0;
    num_steps = '0; blk_mode = 1'b0;
    #3;
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_res_valid",  64'(res_valid),  64'd0);
    chk("rst_step_cnt",   64'(step_cnt),   64'd0);
    check_res("rst", 32'd0, 32'd0, 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // T1: N=1 parallel
    do_load(30, 20, 15, 5, 1, 1'b0);
    chk("t1_busy_run",   64'(busy),       64'd1);
    chk("t1_lr_run",     64'(load_ready), 64'd0);
    chk("t1_rv_run",     64'(res_valid),  64'd0);
    tick();
    chk("t1_rv",         64'(res_valid),  64'd1);
    chk("t1_busy_done",  64'(busy),       64'd0);
    chk("t1_step_cnt",   64'(step_cnt),   64'd1);
    check_res("t1", 32'd4, 32'd30, 32'd27);
    consume();
    chk("t1_rv_clr",     64'(res_valid),  64'd0);
    chk("t1_lr_back",    64'(load_ready), 64'd1);

    // T2: N=2 parallel, plus load request ignored in DONE
    do_load(30, 20, 15, 5, 2, 1'b0);
    chk("t2_busy1",      64'(busy),       64'd1);
    tick();
    chk("t2_busy2",      64'(busy),       64'd1);
    chk("t2_cnt_mid",    64'(step_cnt),   64'd1);
    tick();
    chk("t2_rv",         64'(res_valid),  64'd1);
    chk("t2_busy_done",  64'(busy),       64'd0);
    chk("t2_step_cnt",   64'(step_cnt),   64'd2);
    check_res("t2", 32'd20, 32'd20, 32'd31);
    load_a = 32'hDEAD; load_c = 32'hBEEF; load_d = 32'h1234; num_steps = 3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("t2_ign_rv",     64'(res_valid),  64'd1);
    check_res("t2_ign", 32'd20, 32'd20, 32'd31);
    consume();

    // T3: N=1 serial
    do_load(30, 20, 15, 5, 1, 1'b1);
    tick();
    chk("t3_rv",         64'(res_valid),  64'd1);
    check_res("t3", 32'd4, 32'd20, 32'd1);
    consume();

    // T4: N=0, result held while res_ready low
    do_load(32'h12345678, 32'hFFFF0000, 32'h0F0F0F0F, 32'hA5A5A5A5, 0, 1'b0);
    chk("t4_rv_first",   64'(res_valid),  64'd1);
    chk("t4_busy",       64'(busy),       64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_rv_hold",  64'(res_valid),  64'd1);
      check_res("t4_hold", 32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5);
      tick();
    end
    consume();
    chk("t4_rv_clr",     64'(res_valid),  64'd0);

    // T5: N=200, flush once 50 steps have completed
    do_load(30, 20, 15, 5, 200, 1'b0);
    for (int i = 0; i < 50; i++) tick();
    chk("t5_cnt_pre",    64'(step_cnt),   64'd50);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_lr",         64'(load_ready), 64'd1);
    chk("t5_busy",       64'(busy),       64'd0);
    chk("t5_rv",         64'(res_valid),  64'd0);
    chk("t5_step_cnt",   64'(step_cnt),   64'd50);
    do_load(30, 20, 15, 5, 1, 1'b0);
    chk("t5_reload_busy", 64'(busy),      64'd1);
    tick();
    chk("t5_reload_rv",  64'(res_valid),  64'd1);
    check_res("t5_reload", 32'd4, 32'd30, 32'd27);
    consume();

    // T6: async reset mid-run
    do_load(30, 20, 15, 5, 200, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_cnt_pre",    64'(step_cnt),   64'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_lr",         64'(load_ready), 64'd1);
    chk("t6_busy",       64'(busy),       64'd0);
    chk("t6_rv",         64'(res_valid),  64'd0);
    chk("t6_step_cnt",   64'(step_cnt),   64'd0);
    check_res("t6_rst", 32'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    do_load(30, 20, 15, 5, 1, 1'b1);
    tick();
    chk("t6_rv",         64'(res_valid),  64'd1);
    check_res("t6_after", 32'd4, 32'd20, 32'd1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
